data_memory_bus: RTL and testbench

- Parametrised successor to the single-cycle word data memory.
- Byte-addressed, byte-enabled data RAM for the MIPS datapath/LSU, supporting byte, halfword and word loads and stores.
- Signed and unsigned load extension; misalignment detection.
- Valid/ready request handshake with configurable wait states, so slower memory timing can be modelled without datapath changes.

---
 rtl/data_memory_bus.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory_bus.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bus.sv
// Byte-addressed, byte-enabled data RAM for the MIPS LSU.
// A request is accepted in IDLE, waits WAIT_STATES cycles in BUSY, is
// performed on the last BUSY edge, and answered with a one-cycle pulse in RESP.
// Loads can be byte, halfword or word, with sign or zero extension.
// Misaligned or reserved-size requests report an error and never write.
module data_memory_bus #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // An error is a reserved size, or an access that does not sit on its
    // natural boundary.
    function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = off[0];
            2'b10:   err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    state_t             state_r, state_next_s;
    logic [3:0]         cnt_r, cnt_next_s;
    logic               access_s;
    logic               wr_r, uns_r;
    logic [1:0]         size_r;
    logic [ADDR_W+1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic               resp_valid_r, req_ready_r, resp_err_r;
    logic [31:0]        resp_rdata_r;

    // The array starts cleared at time zero and is never reset afterwards.
    logic [31:0]        mem_r [DEPTH] = '{default: 32'd0};

    logic [ADDR_W-1:0]  word_idx_s;
    logic [1:0]         off_s;
    logic               err_s;
    logic [3:0]         be_s;
    logic [31:0]        wlane_s;
    logic [31:0]        rd_word_s;
    logic [7:0]         rd_byte_s;
    logic [15:0]        rd_half_s;
    logic [31:0]        load_s;

    // Address bits above the array size are deliberately ignored, so
    // addresses wrap around the array.
    logic               unused_addr_s;
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    assign word_idx_s = addr_r[ADDR_W+1:2];
    assign off_s      = addr_r[1:0];
    assign err_s      = req_error(size_r, off_s);
    assign rd_word_s  = mem_r[word_idx_s];

    // Next-state logic; the array access happens on the edge that leaves BUSY.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        access_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = BUSY;
                    cnt_next_s   = WAIT_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != 4'd0) begin
                    cnt_next_s = cnt_r - 4'd1;
                end else begin
                    access_s     = 1'b1;
                    state_next_s = RESP;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Store lane enables and store data replicated onto every lane.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = 32'd0;
        case (size_r)
            2'b00: begin
                be_s    = 4'b0001 << off_s;
                wlane_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                if (off_s[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wlane_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wlane_s = wdata_r;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = 32'd0;
            end
        endcase
    end

    // Load lane selection followed by sign or zero extension.
    always_comb begin
        case (off_s)
            2'b00:   rd_byte_s = rd_word_s[7:0];
            2'b01:   rd_byte_s = rd_word_s[15:8];
            2'b10:   rd_byte_s = rd_word_s[23:16];
            2'b11:   rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = 8'd0;
        endcase
        if (off_s[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
        case (size_r)
            2'b00:   load_s = uns_r ? {24'd0, rd_byte_s} : {{24{rd_byte_s[7]}}, rd_byte_s};
            2'b01:   load_s = uns_r ? {16'd0, rd_half_s} : {{16{rd_half_s[15]}}, rd_half_s};
            2'b10:   load_s = rd_word_s;
            default: load_s = 32'd0;
        endcase
    end

    // FSM state, the request latch and the registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            wr_r         <= 1'b0;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= 32'd0;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            resp_valid_r <= (state_next_s == RESP);
            req_ready_r  <= (state_next_s == IDLE);
            if (state_r == IDLE && req_valid) begin
                wr_r    <= req_write;
                size_r  <= req_size;
                uns_r   <= req_unsigned;
                addr_r  <= req_addr[ADDR_W+1:0];
                wdata_r <= req_wdata[31:0];
            end
            if (access_s) begin
                resp_err_r   <= err_s;
                resp_rdata_r <= (err_s || wr_r) ? 32'd0 : load_s;
            end
        end
    end

    // Byte-enabled array write; errored requests never reach the array.
    always_ff @(posedge clk) begin
        if (access_s && wr_r && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_memory_bus.sv
// Directed bench for data_memory_bus: one instance with no wait states runs
// a vector table, a second instance with three wait states covers the
// multi-cycle corners (held req_valid, mid-operation reset).
module tb_data_memory_bus;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        drv_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    int          cur = 0;

    logic        valid0, ready0, rvalid0, err0;
    logic        valid3, ready3, rvalid3, err3;
    logic [31:0] rdata0, rdata3;
    logic        cur_ready, cur_rvalid, cur_err;
    logic [31:0] cur_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    assign valid0     = drv_valid && (cur == 0);
    assign valid3     = drv_valid && (cur == 1);
    assign cur_ready  = (cur == 1) ? ready3  : ready0;
    assign cur_rvalid = (cur == 1) ? rvalid3 : rvalid0;
    assign cur_err    = (cur == 1) ? err3    : err0;
    assign cur_rdata  = (cur == 1) ? rdata3  : rdata0;

    always #5 clk = ~clk;

    data_memory_bus #(.DATA_W(32), .ADDR_W(6), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(valid0), .req_ready(ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid0),
        .resp_rdata(rdata0), .resp_err(err0)
    );

    data_memory_bus #(.DATA_W(32), .ADDR_W(6), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(valid3), .req_ready(ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid3),
        .resp_rdata(rdata3), .resp_err(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er_d, input logic e);
        vec_t v;
        v.wr = wr; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = er_d; v.exp_err = e;
        return v;
    endfunction

    // Wait (bounded) for resp_valid, sampling on negedges; returns the number
    // of rising edges after the acceptance edge, or -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!cur_rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!cur_rvalid) lat = -1;
    endtask

    // One full transaction on the selected instance with all its checks.
    task automatic do_req(input vec_t v, input string tag);
        int lat;
        int ws;
        ws = (cur == 1) ? 3 : 0;
        @(negedge clk);
        chk({tag, "_ready_idle"}, {31'd0, cur_ready}, 32'd1);
        req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        wait_resp(lat);
        chk({tag, "_latency"}, lat, ws + 1);
        chk({tag, "_rdata"}, cur_rdata, v.exp_rdata);
        chk({tag, "_err"}, {31'd0, cur_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, cur_rvalid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, cur_ready}, 32'd1);
        chk({tag, "_rdata_hold"}, cur_rdata, v.exp_rdata);
    endtask

    vec_t tbl[24];

    initial begin
        int lat;
        int seen;

        tbl[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        tbl[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        tbl[2]  = mk(1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0);
        tbl[3]  = mk(1'b1, 2'b00, 1'b0, 32'h21,  32'hFFFFFF80, 32'h0,        1'b0);
        tbl[4]  = mk(1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'hFFFFFF80, 1'b0);
        tbl[5]  = mk(1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h00000080, 1'b0);
        tbl[6]  = mk(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h11228044, 1'b0);
        tbl[7]  = mk(1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        32'h00000011, 1'b0);
        tbl[8]  = mk(1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h00001122, 1'b0);
        tbl[9]  = mk(1'b1, 2'b10, 1'b0, 32'h30,  32'h00001357, 32'h0,        1'b0);
        tbl[10] = mk(1'b1, 2'b01, 1'b0, 32'h32,  32'h1234A5A5, 32'h0,        1'b0);
        tbl[11] = mk(1'b0, 2'b01, 1'b0, 32'h32,  32'h0,        32'hFFFFA5A5, 1'b0);
        tbl[12] = mk(1'b0, 2'b01, 1'b1, 32'h32,  32'h0,        32'h0000A5A5, 1'b0);
        tbl[13] = mk(1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        32'hA5A51357, 1'b0);
        tbl[14] = mk(1'b1, 2'b10, 1'b0, 32'h40,  32'h0BADF00D, 32'h0,        1'b0);
        tbl[15] = mk(1'b1, 2'b10, 1'b0, 32'h41,  32'hFFFFFFFF, 32'h0,        1'b1);
        tbl[16] = mk(1'b0, 2'b01, 1'b0, 32'h43,  32'h0,        32'h0,        1'b1);
        tbl[17] = mk(1'b0, 2'b11, 1'b0, 32'h40,  32'h0,        32'h0,        1'b1);
        tbl[18] = mk(1'b1, 2'b11, 1'b0, 32'h40,  32'h55555555, 32'h0,        1'b1);
        tbl[19] = mk(1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'h0BADF00D, 1'b0);
        tbl[20] = mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEBABE, 32'h0,        1'b0);
        tbl[21] = mk(1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'hCAFEBABE, 1'b0);
        tbl[22] = mk(1'b0, 2'b10, 1'b0, 32'h110, 32'h0,        32'hDEADBEEF, 1'b0);
        tbl[23] = mk(1'b0, 2'b00, 1'b1, 32'h20,  32'h0,        32'h00000044, 1'b0);

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        chk("rst_ready0",  {31'd0, ready0},  32'd1);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0",  rdata0,           32'd0);
        chk("rst_err0",    {31'd0, err0},    32'd0);
        chk("rst_ready3",  {31'd0, ready3},  32'd1);
        chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", {31'd0, ready0}, 32'd1);
        chk("post_rst_rvalid0", {31'd0, rvalid0}, 32'd0);

        // Vector table on the zero-wait-state instance.
        cur = 0;
        for (int i = 0; i < 24; i++) begin
            do_req(tbl[i], $sformatf("v%0d", i));
        end

        // Wait-state instance: req_valid held through BUSY must not start a
        // second request, and the latched store data must be used.
        cur = 1;
        do_req(mk(1'b1, 2'b10, 1'b0, 32'h64, 32'h01020304, 32'h0, 1'b0), "ws_pre64");
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h60; req_wdata = 32'hAAAA5555; drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_ready_busy", {31'd0, ready3}, 32'd0);
        req_addr = 32'h64; req_wdata = 32'hBBBBBBBB;
        wait_resp(lat);
        chk("hold_latency", lat, 4);
        drv_valid = 1'b0;
        @(negedge clk);
        chk("hold_pulse_end", {31'd0, rvalid3}, 32'd0);
        chk("hold_ready_back", {31'd0, ready3}, 32'd1);
        do_req(mk(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'hAAAA5555, 1'b0), "hold_rd60");
        do_req(mk(1'b0, 2'b10, 1'b0, 32'h64, 32'h0, 32'h01020304, 1'b0), "hold_rd64");

        // Mid-operation reset drops the store without touching the array.
        do_req(mk(1'b1, 2'b10, 1'b0, 32'h50, 32'hCAFEF00D, 32'h0, 1'b0), "mr_pre50");
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h12345678; drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mr_ready_in_rst", {31'd0, ready3}, 32'd1);
        chk("mr_rvalid_in_rst", {31'd0, rvalid3}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid3) seen++;
        end
        chk("mr_no_resp", seen, 0);
        chk("mr_ready_after", {31'd0, ready3}, 32'd1);
        do_req(mk(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0), "mr_rd50");

        // The other instance was reset too; its array must be intact.
        cur = 0;
        do_req(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0), "mr_rd10_dut0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
